// File: rtl/wallace_tree_multiplier_8bit_if.sv
// Operand/product bundle for the 8x8 Wallace-tree multiplier.
// The master drives the operands and the slave returns the registered product.
interface wallace_tree_multiplier_8bit_if;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;

  modport master (output a, output b, input result);
  modport slave  (input a, input b, output result);
endinterface

// File: rtl/wallace_tree_multiplier_8bit.sv
// Unsigned 8x8 multiplier: AND partial-product array, Wallace 3:2/2:2 column
// reduction, ripple carry-propagate adder, and one registered 16-bit product.
module wallace_tree_multiplier_8bit (
  input  logic                          clk,
  input  logic                          rst,
  wallace_tree_multiplier_8bit_if.slave bus
);

  logic [7:0][7:0] pp;
  logic [15:0]     result_next;
  logic [15:0]     result_reg;

  // pp[i][j] carries weight 2^(i+j)
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp_row
      for (genvar gj = 0; gj < 8; gj++) begin : g_pp_col
        assign pp[gi][gj] = bus.a[gj] & bus.b[gi];
      end
    end
  endgenerate

  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic z);
    full_adder = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] half_adder(input logic x, input logic y);
    half_adder = {x & y, x ^ y};
  endfunction

  // Column heights depend only on position, so every loop bound and index
  // collapses to a constant and the result is a fixed network of AND/HA/FA cells.
  function automatic logic [15:0] wallace_product(input logic [7:0][7:0] p);
    logic [7:0]  col  [17];
    logic [7:0]  ncol [17];
    int          h    [17];
    int          nh   [17];
    int          idx;
    int          max_h;
    logic [1:0]  sc;
    logic [15:0] row0;
    logic [15:0] row1;
    logic [15:0] sum;
    logic        carry;

    for (int k = 0; k < 17; k++) begin
      col[5'(k)]  = '0;
      ncol[5'(k)] = '0;
      h[5'(k)]    = 0;
      nh[5'(k)]   = 0;
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col[5'(i + j)][3'(h[5'(i + j)])] = p[3'(i)][3'(j)];
        h[5'(i + j)] = h[5'(i + j)] + 1;
      end
    end

    max_h = 8;
    for (int layer = 0; layer < 6; layer++) begin
      if (max_h > 2) begin
        for (int k = 0; k < 17; k++) begin
          ncol[5'(k)] = '0;
          nh[5'(k)]   = 0;
        end
        for (int k = 0; k < 16; k++) begin
          idx = 0;
          for (int g = 0; g < 2; g++) begin
            if (h[5'(k)] - idx >= 3) begin
              sc = full_adder(col[5'(k)][3'(idx)], col[5'(k)][3'(idx + 1)],
                              col[5'(k)][3'(idx + 2)]);
              ncol[5'(k)][3'(nh[5'(k)])]         = sc[0];
              nh[5'(k)]                          = nh[5'(k)] + 1;
              ncol[5'(k + 1)][3'(nh[5'(k + 1)])] = sc[1];
              nh[5'(k + 1)]                      = nh[5'(k + 1)] + 1;
              idx                                = idx + 3;
            end
          end
          if (h[5'(k)] - idx == 2) begin
            sc = half_adder(col[5'(k)][3'(idx)], col[5'(k)][3'(idx + 1)]);
            ncol[5'(k)][3'(nh[5'(k)])]         = sc[0];
            nh[5'(k)]                          = nh[5'(k)] + 1;
            ncol[5'(k + 1)][3'(nh[5'(k + 1)])] = sc[1];
            nh[5'(k + 1)]                      = nh[5'(k + 1)] + 1;
          end else if (h[5'(k)] - idx == 1) begin
            ncol[5'(k)][3'(nh[5'(k)])] = col[5'(k)][3'(idx)];
            nh[5'(k)]                  = nh[5'(k)] + 1;
          end
        end
        max_h = 0;
        for (int k = 0; k < 17; k++) begin
          col[5'(k)] = ncol[5'(k)];
          h[5'(k)]   = nh[5'(k)];
          if (k < 16 && nh[5'(k)] > max_h) begin
            max_h = nh[5'(k)];
          end
        end
      end
    end

    // Column 16 only ever holds carries that are provably zero (product < 2^16)
    for (int k = 0; k < 16; k++) begin
      row0[4'(k)] = (h[5'(k)] > 0) ? col[5'(k)][0] : 1'b0;
      row1[4'(k)] = (h[5'(k)] > 1) ? col[5'(k)][1] : 1'b0;
    end

    carry = 1'b0;
    for (int k = 0; k < 16; k++) begin
      sc          = full_adder(row0[4'(k)], row1[4'(k)], carry);
      sum[4'(k)]  = sc[0];
      carry       = sc[1];
    end
    wallace_product = sum;
  endfunction

  always_comb begin
    result_next = wallace_product(pp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign bus.result = result_reg;

endmodule

// File: tb/tb_wallace_tree_multiplier_8bit.sv
// Directed, random and exhaustive checks of the registered 8x8 multiplier.
module tb_wallace_tree_multiplier_8bit;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  wallace_tree_multiplier_8bit_if bus ();

  wallace_tree_multiplier_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: result=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive operands between edges, then sample just after the next rising edge.
  task automatic apply_check(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input logic [15:0] exp, input bit verbose);
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    if (verbose) $display("[TB] %s: a=%0d b=%0d result=%0d expected=%0d", tag, x, y, bus.result, exp);
    check_eq(tag, bus.result, exp);
  endtask

  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [15:0] sweep_exp;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    bus.a = 8'd255;
    bus.b = 8'd255;

    // Reset held for two edges with max operands
    @(posedge clk); #1;
    $display("[TB] reset edge 1: result=%0d", bus.result);
    check_eq("reset_edge1", bus.result, 16'd0);
    @(posedge clk); #1;
    $display("[TB] reset edge 2: result=%0d", bus.result);
    check_eq("reset_edge2", bus.result, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset release: result=%0d", bus.result);
    check_eq("reset_release", bus.result, 16'd65025);

    apply_check("dir_0x0",     8'd0,   8'd0,   16'd0,     1'b1);
    apply_check("dir_1x1",     8'd1,   8'd1,   16'd1,     1'b1);
    apply_check("dir_15x10",   8'd15,  8'd10,  16'd150,   1'b1);
    apply_check("dir_255x255", 8'd255, 8'd255, 16'd65025, 1'b1);
    apply_check("dir_128x2",   8'd128, 8'd2,   16'd256,   1'b1);
    apply_check("dir_100x25",  8'd100, 8'd25,  16'd2500,  1'b1);

    // Walking-one multiplier against all-ones multiplicand
    sweep_exp = 16'd255;
    for (int k = 0; k < 8; k++) begin
      apply_check("col_255_shift", 8'd255, 8'(1 << k), sweep_exp, 1'b1);
      sweep_exp = sweep_exp << 1;
    end
    apply_check("col_aa_55", 8'hAA, 8'h55, 16'd14450, 1'b1);

    // Back-to-back operands, one product per edge
    apply_check("b2b_3x7",     8'd3,   8'd7,   16'd21,    1'b1);
    apply_check("b2b_200x200", 8'd200, 8'd200, 16'd40000, 1'b1);
    apply_check("b2b_0x255",   8'd0,   8'd255, 16'd0,     1'b1);
    apply_check("b2b_17x13",   8'd17,  8'd13,  16'd221,   1'b1);

    // Reset mid-stream discards the in-flight product
    apply_check("mid_100x25", 8'd100, 8'd25, 16'd2500, 1'b1);
    @(negedge clk);
    rst   = 1'b1;
    bus.a = 8'd255;
    bus.b = 8'd255;
    #1;
    check_eq("mid_rst_sync_hold", bus.result, 16'd2500);
    @(posedge clk); #1;
    $display("[TB] mid reset edge: result=%0d", bus.result);
    check_eq("mid_rst_edge", bus.result, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.a = 8'd2;
    bus.b = 8'd3;
    @(posedge clk); #1;
    $display("[TB] mid reset release: a=2 b=3 result=%0d", bus.result);
    check_eq("mid_release_2x3", bus.result, 16'd6);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      apply_check("random", ra, rb, 16'(int'(ra) * int'(rb)), 1'b0);
    end
    $display("[TB] random: 1000 pairs applied");

    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        apply_check("exhaustive", 8'(ia), 8'(ib), 16'(ia * ib), 1'b0);
      end
    end
    $display("[TB] exhaustive: 65536 pairs applied");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
